// File: rtl/alu_sequencer.sv
// alu_sequencer: drives the ALU function select and operand buses to build
// SUB, OR, XOR and MUL out of the ALU primitives ADD, AND, NOT and PASSA.
// The sequencer performs one ALU pass per clock and uses a
// start/ready/done handshake.
module alu_sequencer #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Start,
  input  logic [1:0]       Op,
  input  logic [WIDTH-1:0] X,
  input  logic [WIDTH-1:0] Y,
  output logic             Ready,
  output logic             Done,
  output logic [WIDTH-1:0] Result,
  output logic [1:0]       AluFn,
  output logic [WIDTH-1:0] AluA,
  output logic [WIDTH-1:0] AluB,
  input  logic [WIDTH-1:0] AluOut
);

  // Counter holds the step index (0..6) for the logic ops and the iteration
  // index (0..WIDTH) for MUL, so it needs at least 3 bits.
  localparam int unsigned CntW = ($clog2(WIDTH + 1) > 3) ? $clog2(WIDTH + 1) : 3;

  localparam logic [1:0] OpSub = 2'b00;
  localparam logic [1:0] OpOr  = 2'b01;
  localparam logic [1:0] OpXor = 2'b10;
  localparam logic [1:0] OpMul = 2'b11;

  localparam logic [1:0] FnAdd   = 2'b00;
  localparam logic [1:0] FnAnd   = 2'b01;
  localparam logic [1:0] FnNot   = 2'b10;
  localparam logic [1:0] FnPassa = 2'b11;

  // StStep walks the per-op micro-program indexed by {op_q, cnt_q}.
  localparam logic [1:0] StIdle   = 2'd0;
  localparam logic [1:0] StStep   = 2'd1;
  localparam logic [1:0] StMulAdd = 2'd2;
  localparam logic [1:0] StMulDbl = 2'd3;

  logic [1:0]       state_q, state_d;
  logic [1:0]       op_q, op_d;
  logic [WIDTH-1:0] ra_q, ra_d;
  logic [WIDTH-1:0] rb_q, rb_d;
  logic [WIDTH-1:0] t_q, t_d;
  logic [WIDTH-1:0] u_q, u_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             done_q, done_d;

  logic [1:0]       alu_fn;
  logic [WIDTH-1:0] alu_a;
  logic [WIDTH-1:0] alu_b;
  logic             finish;

  // Bus drive and next-state: one ALU pass per state, result captured from
  // the combinational AluOut on the closing edge of the same cycle.
  always_comb begin
    alu_fn   = FnPassa;
    alu_a    = result_q;
    alu_b    = '0;
    finish   = 1'b0;
    state_d  = state_q;
    op_d     = op_q;
    ra_d     = ra_q;
    rb_d     = rb_q;
    t_d      = t_q;
    u_d      = u_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    result_d = result_q;

    unique case (state_q)
      StIdle: begin
        if (Start) begin
          ra_d    = X;
          rb_d    = Y;
          acc_d   = '0;
          cnt_d   = '0;
          op_d    = Op;
          state_d = (Op == OpMul) ? StMulAdd : StStep;
        end
      end

      StStep: begin
        cnt_d = cnt_q + CntW'(1);
        unique case (op_q)
          OpSub: begin
            case (cnt_q)
              CntW'(0): begin alu_fn = FnNot; alu_a = rb_q; t_d = AluOut; end
              CntW'(1): begin
                alu_fn = FnAdd; alu_a = t_q; alu_b = WIDTH'(1); t_d = AluOut;
              end
              default: begin alu_fn = FnAdd; alu_a = ra_q; alu_b = t_q; finish = 1'b1; end
            endcase
          end
          OpOr: begin
            case (cnt_q)
              CntW'(0): begin alu_fn = FnNot; alu_a = ra_q; t_d = AluOut; end
              CntW'(1): begin alu_fn = FnNot; alu_a = rb_q; u_d = AluOut; end
              CntW'(2): begin alu_fn = FnAnd; alu_a = t_q; alu_b = u_q; t_d = AluOut; end
              default: begin alu_fn = FnNot; alu_a = t_q; finish = 1'b1; end
            endcase
          end
          OpXor: begin
            // (A OR B) AND NOT (A AND B)
            case (cnt_q)
              CntW'(0): begin alu_fn = FnNot; alu_a = ra_q; t_d = AluOut; end
              CntW'(1): begin alu_fn = FnNot; alu_a = rb_q; u_d = AluOut; end
              CntW'(2): begin alu_fn = FnAnd; alu_a = t_q; alu_b = u_q; t_d = AluOut; end
              CntW'(3): begin alu_fn = FnNot; alu_a = t_q; t_d = AluOut; end
              CntW'(4): begin alu_fn = FnAnd; alu_a = ra_q; alu_b = rb_q; u_d = AluOut; end
              CntW'(5): begin alu_fn = FnNot; alu_a = u_q; u_d = AluOut; end
              default: begin alu_fn = FnAnd; alu_a = t_q; alu_b = u_q; finish = 1'b1; end
            endcase
          end
          default: begin
            // MUL never runs from StStep; recover to idle if it somehow does.
            state_d = StIdle;
          end
        endcase
        if (finish) begin
          result_d = AluOut;
          state_d  = StIdle;
        end
      end

      StMulAdd: begin
        alu_fn  = FnAdd;
        alu_a   = acc_q;
        alu_b   = rb_q[0] ? ra_q : '0;
        acc_d   = AluOut;
        state_d = StMulDbl;
      end

      StMulDbl: begin
        alu_fn = FnAdd;
        alu_a  = ra_q;
        alu_b  = ra_q;
        ra_d   = AluOut;
        rb_d   = rb_q >> 1;
        cnt_d  = cnt_q + CntW'(1);
        if (cnt_q == CntW'(WIDTH - 1)) begin
          finish   = 1'b1;
          result_d = acc_q;
          state_d  = StIdle;
        end else begin
          state_d = StMulAdd;
        end
      end

      default: state_d = StIdle;
    endcase
  end

  // State and datapath registers; reset aborts any operation in flight.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q  <= StIdle;
      op_q     <= OpSub;
      ra_q     <= '0;
      rb_q     <= '0;
      t_q      <= '0;
      u_q      <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      result_q <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      ra_q     <= ra_d;
      rb_q     <= rb_d;
      t_q      <= t_d;
      u_q      <= u_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      done_q   <= finish;
    end
  end

  assign Ready  = (state_q == StIdle);
  assign Done   = done_q;
  assign Result = result_q;
  assign AluFn  = alu_fn;
  assign AluA   = alu_a;
  assign AluB   = alu_b;

endmodule

// File: tb/tb_alu_sequencer.sv
// Scoreboard bench for alu_sequencer with a behavioural ALU model attached.
module tb_alu_sequencer;

  logic        Clk = 1'b0;
  logic        Reset = 1'b1;
  logic        Start = 1'b0;
  logic [1:0]  Op = 2'b00;
  logic [15:0] X = '0;
  logic [15:0] Y = '0;
  logic        Ready;
  logic        Done;
  logic [15:0] Result;
  logic [1:0]  AluFn;
  logic [15:0] AluA;
  logic [15:0] AluB;
  logic [15:0] AluOut;

  alu_sequencer #(.WIDTH(16)) dut (
    .Clk(Clk), .Reset(Reset), .Start(Start), .Op(Op), .X(X), .Y(Y),
    .Ready(Ready), .Done(Done), .Result(Result), .AluFn(AluFn),
    .AluA(AluA), .AluB(AluB), .AluOut(AluOut)
  );

  // eLC-3 ALU: ADD, AND, NOT, PASSA
  always_comb begin
    AluOut = AluA;
    case (AluFn)
      2'b00: AluOut = AluA + AluB;
      2'b01: AluOut = AluA & AluB;
      2'b10: AluOut = ~AluA;
      default: AluOut = AluA;
    endcase
  end

  always #5 Clk = ~Clk;

  typedef struct {
    logic [15:0] res;
    int          due;
    string       name;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   vectors = 0;
  int   miscompares = 0;

  always @(posedge Clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: every Done must match the oldest outstanding expectation,
  // both in value and in the edge it arrives on.
  always @(negedge Clk) begin
    if (!Reset && Done) begin
      if (sb.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_done: got Result 0x%0h, expected no Done", Result);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk({e.name, "_result"}, 32'(Result), 32'(e.res));
        chk({e.name, "_latency"}, 32'(cyc), 32'(e.due));
      end
    end
  end

  // Call at a negedge while Ready is expected high; accept edge is the next posedge.
  task automatic drive(input logic [1:0] op, input logic [15:0] x, input logic [15:0] y,
                       input logic [15:0] exp, input int n, input string name);
    exp_t e;
    chk({name, "_ready_at_start"}, 32'(Ready), 32'd1);
    Start = 1'b1;
    Op = op;
    X = x;
    Y = y;
    e.res = exp;
    e.due = cyc + 1 + n;
    e.name = name;
    sb.push_back(e);
    @(posedge Clk);
    #1 Start = 1'b0;
  endtask

  task automatic issue(input logic [1:0] op, input logic [15:0] x, input logic [15:0] y,
                       input logic [15:0] exp, input int n, input string name);
    @(negedge Clk);
    drive(op, x, y, exp, n, name);
  endtask

  task automatic wait_drain(input string name);
    for (int i = 0; i < 100 && sb.size() != 0; i++) @(negedge Clk);
    if (sb.size() != 0) begin
      vectors++;
      miscompares++;
      $display("FAIL %s_timeout: got %0d pending, expected 0", name, sb.size());
      sb.delete();
    end
  endtask

  task automatic wait_done(input string name);
    int i;
    i = 0;
    @(negedge Clk);
    while (!Done && i < 100) begin
      @(negedge Clk);
      i++;
    end
    if (!Done) begin
      vectors++;
      miscompares++;
      $display("FAIL %s_done_timeout: got Done 0, expected 1", name);
    end
  endtask

  task automatic idle_bus(input string name, input logic [15:0] res);
    repeat (3) begin
      @(negedge Clk);
      chk({name, "_idle_fn"}, 32'(AluFn), 32'd3);
      chk({name, "_idle_a"}, 32'(AluA), 32'(res));
      chk({name, "_idle_b"}, 32'(AluB), 32'd0);
      chk({name, "_idle_ready"}, 32'(Ready), 32'd1);
    end
  endtask

  initial begin
    // Reset state
    @(posedge Clk);
    #1;
    chk("rst_ready", 32'(Ready), 32'd1);
    chk("rst_done", 32'(Done), 32'd0);
    chk("rst_result", 32'(Result), 32'd0);
    chk("rst_fn", 32'(AluFn), 32'd3);
    chk("rst_a", 32'(AluA), 32'd0);
    chk("rst_b", 32'(AluB), 32'd0);
    @(negedge Clk);
    Reset = 1'b0;

    // 1. SUB 5-7 with first-step bus and busy Ready checks
    issue(2'b00, 16'h0005, 16'h0007, 16'hFFFE, 3, "sub_5_7");
    chk("sub_step1_fn", 32'(AluFn), 32'd2);
    chk("sub_step1_a", 32'(AluA), 32'h0007);
    chk("sub_busy_e", 32'(Ready), 32'd0);
    @(posedge Clk);
    #1 chk("sub_busy_e1", 32'(Ready), 32'd0);
    @(posedge Clk);
    #1 chk("sub_busy_e2", 32'(Ready), 32'd0);
    wait_drain("sub_5_7");
    idle_bus("sub_5_7", 16'hFFFE);

    // 2. OR and XOR
    issue(2'b01, 16'hF0F0, 16'h0FF0, 16'hFFF0, 4, "or");
    wait_drain("or");
    issue(2'b10, 16'hF0F0, 16'h0FF0, 16'hFF00, 7, "xor");
    wait_drain("xor");
    idle_bus("xor", 16'hFF00);

    // 3. MUL
    issue(2'b11, 16'd300, 16'd300, 16'h5F90, 32, "mul_300");
    wait_drain("mul_300");
    issue(2'b11, 16'hFFFF, 16'hFFFF, 16'h0001, 32, "mul_ffff");
    wait_drain("mul_ffff");
    issue(2'b11, 16'h1234, 16'h0000, 16'h0000, 32, "mul_y0");
    wait_drain("mul_y0");
    idle_bus("mul_y0", 16'h0000);

    // 4. Start while busy is ignored; back-to-back SUB in the Done cycle
    issue(2'b01, 16'hAAAA, 16'h5555, 16'hFFFF, 4, "or_busy");
    @(negedge Clk);
    chk("busy_ready", 32'(Ready), 32'd0);
    Start = 1'b1;
    Op = 2'b11;
    X = 16'h0003;
    Y = 16'h0003;
    @(negedge Clk);
    Start = 1'b0;
    wait_done("or_busy");
    drive(2'b00, 16'd9, 16'd4, 16'h0005, 3, "sub_b2b");
    wait_drain("sub_b2b");
    idle_bus("sub_b2b", 16'h0005);

    // 5. Reset asynchronously on cycle 10 of a MUL
    issue(2'b11, 16'd300, 16'd300, 16'h5F90, 32, "mul_abort");
    repeat (9) @(posedge Clk);
    #2 Reset = 1'b1;
    sb.delete();
    #1;
    chk("abort_ready", 32'(Ready), 32'd1);
    chk("abort_done", 32'(Done), 32'd0);
    chk("abort_result", 32'(Result), 32'd0);
    chk("abort_fn", 32'(AluFn), 32'd3);
    repeat (2) @(negedge Clk);
    Reset = 1'b0;
    idle_bus("abort", 16'h0000);
    repeat (30) @(negedge Clk);
    chk("abort_result_held", 32'(Result), 32'd0);
    issue(2'b00, 16'd1, 16'd2, 16'hFFFF, 3, "sub_1_2");
    wait_drain("sub_1_2");

    // 6. Idle bus stable after completion
    idle_bus("final", 16'hFFFF);
    repeat (5) @(negedge Clk);
    chk("final_result", 32'(Result), 32'hFFFF);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/alu_sequencer.md
# alu_sequencer

Multi-cycle operation sequencer that drives the eLC-3 ALU's function select and operand buses. It synthesises SUB, OR, XOR and MUL from the ALU's four primitives (ADD, AND, NOT, PASSA), one ALU pass per clock. It sits between the instruction control unit and the ALU. A start/ready/done handshake exposes extended operations without changing the ALU.

## Interface
Parameters:
- WIDTH, 16, datapath width; it must equal the ALU width. MUL iteration count equals WIDTH.

Ports:
- Clk  in  1  system clock; all state updates on the rising edge.
- Reset  in  1  asynchronous, active-high. It forces the idle state immediately.
- Start  in  1  operation request. Sampled only while Ready=1.
- Op  in  2  operation select. 00 SUB (X−Y), 01 OR, 10 XOR, 11 MUL (low WIDTH bits of X·Y).
- X, Y  in  WIDTH  operands. Captured on the accept edge.
- Ready  out  1  high in the idle state. Combinational from state.
- Done  out  1  one-cycle pulse; Result is valid in that cycle.
- Result  out  WIDTH  last completed result. Holds until the next completion.
- AluFn  out  2  to ALU Fn (00 ADD, 01 AND, 10 NOT, 11 PASSA).
- AluA, AluB  out  WIDTH  to ALU A, B.
- AluOut  in  WIDTH  from ALU Out. It is combinational, so it is captured on the same edge the step completes.

## Operation
- Internal registers: RA, RB (operand copies), T, U (temporaries), ACC, a step/iteration counter, the latched op, and the state.
- **IDLE**
  - Ready=1.
  - Bus values: AluFn=11, AluA=Result, AluB=0.
  - If Start=1 at a rising edge:
    - RA←X, RB←Y, ACC←0, counter←0, op latched.
    - Enter that op's first step.
- Step sequences (one ALU pass per step; the bus values are combinational from state/registers):
  - SUB, 3 steps:
    - T←NOT RB
    - T←T+1 (AluB=1)
    - Result←RA+T
  - OR, 4 steps:
    - T←NOT RA
    - U←NOT RB
    - T←T AND U
    - Result←NOT T
  - XOR, 7 steps:
    - T←NOT RA
    - U←NOT RB
    - T←T AND U
    - T←NOT T
    - U←RA AND RB
    - U←NOT U
    - Result←T AND U
  - MUL, 2·WIDTH steps; for each iteration i = 0..WIDTH−1:
    - ADD step: ACC←ACC+(RB[0] ? RA : 0).
    - DBL step: RA←RA+RA, RB←RB>>1 (logical, done in the sequencer), counter++.
    - After the final DBL step, Result←ACC.
- On the last step's edge:
  - Write Result.
  - Register Done=1 for exactly one cycle.
  - Return to IDLE, so Ready=1 in the Done cycle.
- Arithmetic: all results wrap modulo 2^WIDTH. There are no flags and no overflow detection.
- Start while Ready=0 is ignored. Op/X/Y changes while busy have no effect.

## Timing
- Reset values:
  - State IDLE, so Ready=1 while Reset is held.
  - Done=0.
  - Result=0.
  - RA, RB, T, U, ACC, counter = 0.
  - AluFn=11, AluA=0, AluB=0.
- Accept edge = the rising edge with Ready=1 and Start=1. Ready drops in the following cycle.
- Latency: Done is high in the cycle following edge N after the accept edge.
  - SUB N=3
  - OR N=4
  - XOR N=7
  - MUL N=2·WIDTH (32)
- Back-to-back: Start=1 during the Done cycle is accepted on that cycle's closing edge. There are no idle bubbles.
- Reset asserted mid-operation:
  - Abort at once and restore all reset values.
  - No Done pulse.
  - The partial result is discarded.
- MUL with Y=0 or X=0 still takes the full 32 cycles and yields 0.
- AluOut is never registered as an output. The sequencer adds no cycles beyond N.

## Test plan
1. SUB, X=0x0005, Y=0x0007, accept at edge E.
   - Step 1 bus: AluFn=10, AluA=0x0007.
   - Done high after edge E+3, Result=0xFFFE.
   - Ready=0 between the accept edge and edge E+3.
2. OR, X=0xF0F0, Y=0x0FF0: Result=0xFFF0 after 4 edges.
   - XOR, same operands: Result=0xFF00 after 7 edges.
3. MUL cases, each with Done after exactly 32 edges:
   - X=300, Y=300: Result=0x5F90 (90000 mod 65536).
   - X=0xFFFF, Y=0xFFFF: Result=0x0001.
   - X=0x1234, Y=0: Result=0x0000.
4. Handshake cases:
   - Start pulsed while busy with a different Op/X/Y: ignored; the first result is unaffected.
   - Start=1 with SUB 9−4 in the Done cycle of a prior OR: accepted; Result=0x0005 exactly 3 edges later.
5. Reset mid-operation: Reset asserted asynchronously between edges on cycle 10 of a MUL.
   - Immediately: Ready=1, Done=0, Result=0, AluFn=11, no Done afterward.
   - After release, SUB 1−2 gives 0xFFFF normally.
6. Idle bus check: after any completion, AluFn=11, AluA=Result, AluB=0, held stable with no Done pulses while Start=0.
